// File: rtl/signal_recorder.sv
// signal_recorder: captures N_SAMPLES readings of i_signal at SAMPLE_DIV-cycle spacing
// after a SW rising edge, then streams them as a HEADER-led byte frame to a UART.
module signal_recorder #(
    parameter int         SAMPLE_DIV = 5_000_000,
    parameter int         N_SAMPLES  = 14,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        SW,
    input  logic [13:0] i_signal,
    output logic [7:0]  o_Tx_Byte,
    output logic        o_Tx_DV,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done,
    output logic        o_busy,
    output logic        o_done
);
    typedef enum logic [1:0] {IDLE, CAPTURE, SEND, WAIT_DONE} state_t;

    localparam logic [23:0] DIV_LAST = 24'(SAMPLE_DIV - 1);
    localparam logic [3:0]  K_LAST   = 4'(N_SAMPLES - 1);
    localparam logic [5:0]  IDX_LAST = 6'(2 * N_SAMPLES);

    state_t      r_state, w_next;
    logic        r_sw_meta, r_sw_sync, r_sw_prev;
    logic [23:0] r_cnt;
    logic [3:0]  r_k;
    logic [5:0]  r_idx;
    logic [13:0] r_buf [16];
    logic [7:0]  r_tx_byte;
    logic        r_tx_dv, r_done;
    logic        w_start, w_tick;
    logic [3:0]  w_slot;
    logic [13:0] w_smp;
    logic [7:0]  w_byte;

    // r_done gates the start so an edge landing on the o_done cycle is dropped
    assign w_start = r_sw_sync & ~r_sw_prev & ~r_done;
    assign w_tick  = r_cnt == 24'd0;
    assign w_slot  = 4'((r_idx - 6'd1) >> 1);
    assign w_smp   = r_buf[w_slot];
    assign w_byte  = (r_idx == 6'd0) ? HEADER : r_idx[0] ? {2'b00, w_smp[13:8]} : w_smp[7:0];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_start) w_next = CAPTURE;
            CAPTURE:   if (w_tick && r_k == K_LAST) w_next = SEND;
            SEND:      if (!i_Tx_Active) w_next = WAIT_DONE;
            WAIT_DONE: if (i_Tx_Done) w_next = (r_idx == IDX_LAST) ? IDLE : SEND;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_sw_meta <= 1'b0;
            r_sw_sync <= 1'b0;
            r_sw_prev <= 1'b0;
            r_cnt     <= 24'd0;
            r_k       <= 4'd0;
            r_idx     <= 6'd0;
            r_tx_byte <= 8'h00;
            r_tx_dv   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            r_sw_prev <= r_sw_sync;
            r_tx_dv   <= 1'b0;
            r_done    <= 1'b0;
            if (r_state == CAPTURE) begin
                r_cnt <= (r_cnt == DIV_LAST) ? 24'd0 : r_cnt + 24'd1;
                if (w_tick) r_k <= r_k + 4'd1;
            end else begin
                r_cnt <= 24'd0;
                r_k   <= 4'd0;
            end
            if (r_state == IDLE) r_idx <= 6'd0;
            if (r_state == SEND && !i_Tx_Active) begin
                r_tx_dv   <= 1'b1;
                r_tx_byte <= w_byte;
            end
            if (r_state == WAIT_DONE && i_Tx_Done) begin
                if (r_idx == IDX_LAST) r_done <= 1'b1;
                else                   r_idx  <= r_idx + 6'd1;
            end
        end
    end

    // sample storage is deliberately left out of reset
    always_ff @(posedge i_Clk) begin
        if (r_state == CAPTURE && w_tick) r_buf[r_k] <= i_signal;
    end

    assign o_Tx_Byte = r_tx_byte;
    assign o_Tx_DV   = r_tx_dv;
    assign o_busy    = r_state != IDLE;
    assign o_done    = r_done;
endmodule

// File: tb/tb_signal_recorder.sv
// tb_signal_recorder: directed runs with a frame/timing model and a UART responder,
// checked every cycle plus literal frame contents.
module tb_signal_recorder;
    localparam int DIV    = 4;
    localparam int NS     = 3;
    localparam int TX_LAT = 3;

    logic        clk = 1'b0, rst_n = 1'b0, sw = 1'b0, tx_active = 1'b0, tx_done = 1'b0;
    logic [13:0] sig = 14'h0;
    logic [7:0]  tx_byte;
    logic        tx_dv, busy, done;

    int cyc = 0, checks = 0, fails = 0;
    int cap_base = -1, exp_dv_cyc = -1, run_start = -1, run_end = -1;
    int bytes_left = 0, tx_cnt = 0, hold = 0, hold_cnt = 0, strobes = 0, done_cnt = 0;
    bit spur = 1'b0;
    logic [13:0] vals [NS];
    logic [7:0]  exp_q [$];
    logic [7:0]  got [$];
    logic [7:0]  last_byte = 8'h00;
    logic [7:0]  f1 [7] = '{8'hA5, 8'h27, 8'h07, 8'h06, 8'hAF, 8'h3F, 8'hFF};
    logic [7:0]  f2 [7] = '{8'hA5, 8'h01, 8'h23, 8'h2A, 8'h5C, 8'h00, 8'h01};

    signal_recorder #(.SAMPLE_DIV(DIV), .N_SAMPLES(NS), .HEADER(8'hA5)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .SW(sw), .i_signal(sig),
        .o_Tx_Byte(tx_byte), .o_Tx_DV(tx_dv), .i_Tx_Active(tx_active),
        .i_Tx_Done(tx_done), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // planned sample values appear only on capture cycles; noise elsewhere
    function automatic logic [13:0] sample_at(int c);
        int d;
        d = c - cap_base;
        if (cap_base >= 0 && d >= 0 && d % DIV == 0 && d / DIV < NS) return vals[d / DIV];
        return 14'(c * 97 + 13);
    endfunction
    always @(cyc) sig = sample_at(cyc);

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    task automatic arm(input logic [13:0] v0, input logic [13:0] v1, input logic [13:0] v2);
        vals[0] = v0;
        vals[1] = v1;
        vals[2] = v2;
        cap_base = cyc + 3;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NS; k++) begin
            exp_q.push_back({2'b00, vals[k][13:8]});
            exp_q.push_back(vals[k][7:0]);
        end
        exp_dv_cyc = cap_base + (NS - 1) * DIV + 2;
        bytes_left = 2 * NS + 1;
        run_start = cap_base;
        run_end = -1;
    endtask

    task automatic wait_until_done(input int target);
        for (int t = 0; t < 400 && done_cnt < target; t++) @(posedge clk);
        #1;
        chk("frame_complete", done_cnt, target);
    endtask

    task automatic wait_strobes(input int target);
        for (int t = 0; t < 400 && strobes < target; t++) @(posedge clk);
        #1;
        chk("strobe_count", strobes, target);
    endtask

    // compare process: every cycle against the model
    always @(negedge clk) begin
        logic exp_dv;
        logic [7:0] eb;
        exp_dv = cyc == exp_dv_cyc;
        chk("tx_dv", tx_dv, exp_dv);
        if (tx_dv) begin
            strobes++;
            got.push_back(tx_byte);
            eb = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            chk("tx_byte", tx_byte, eb);
            last_byte = eb;
        end else begin
            chk("tx_byte_hold", tx_byte, last_byte);
        end
        chk("busy", busy, run_start >= 0 && cyc >= run_start && (run_end < 0 || cyc < run_end));
        chk("done", done, run_end >= 0 && cyc == run_end);
        if (done) done_cnt++;
    end

    // UART responder: busy for TX_LAT cycles per byte, optional extra hold, spurious dones
    initial forever begin
        @(negedge clk);
        #1;
        tx_done = 1'b0;
        if (!rst_n) begin
            tx_active = 1'b0;
            tx_cnt = 0;
            hold_cnt = 0;
        end else if (tx_dv) begin
            tx_active = 1'b1;
            tx_cnt = TX_LAT;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done = 1'b1;
                bytes_left--;
                hold_cnt = bytes_left > 0 ? hold : 0;
                hold = 0;
                tx_active = hold_cnt > 0;
                if (bytes_left == 0) run_end = cyc + 1;
                else exp_dv_cyc = cyc + (hold_cnt > 0 ? hold_cnt + 1 : 2);
            end
        end else if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) tx_active = 1'b0;
            else if (spur) begin
                tx_done = 1'b1;
                spur = 1'b0;
            end
        end else if (spur) begin
            tx_done = 1'b1;
            spur = 1'b0;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dv", tx_dv, 0);
        chk("rst_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        spur = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        sw = 1'b1;
        arm(14'h2707, 14'h06AF, 14'h3FFF);
        repeat (6) @(posedge clk);
        #1;
        spur = 1'b1;
        wait_until_done(1);
        chk("frame1_len", got.size(), 7);
        for (int i = 0; i < 7 && i < got.size(); i++) chk("frame1_byte", got[i], f1[i]);

        repeat (150) @(posedge clk);
        #1;
        chk("held_sw_done", done_cnt, 1);
        chk("held_sw_strobes", strobes, 7);
        sw = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        got.delete();
        hold = 10;
        sw = 1'b1;
        arm(14'h0123, 14'h2A5C, 14'h0001);
        wait_strobes(8);
        repeat (5) @(posedge clk);
        #1;
        spur = 1'b1;
        wait_until_done(2);
        chk("frame2_len", got.size(), 7);
        for (int i = 0; i < 7 && i < got.size(); i++) chk("frame2_byte", got[i], f2[i]);

        sw = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        sw = 1'b1;
        arm(14'h1111, 14'h2222, 14'h3333);
        wait_strobes(17);
        rst_n = 1'b0;
        sw = 1'b0;
        exp_q.delete();
        exp_dv_cyc = -1;
        run_start = -1;
        run_end = -1;
        cap_base = -1;
        last_byte = 8'h00;
        repeat (2) @(negedge clk);
        chk("midrun_rst_dv", tx_dv, 0);
        chk("midrun_rst_byte", tx_byte, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_strobes", strobes, 17);
        chk("post_rst_done", done_cnt, 2);

        rst_n = 1'b0;
        sw = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        arm(14'h1234, 14'h0FF0, 14'h3C3C);
        wait_until_done(3);
        chk("sw_high_at_release_strobes", strobes, 24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/signal_recorder.md
SIGNAL_RECORDER -- requirements
Module: SIGNAL_RECORDER

Interface
REQ-001 Parameter SAMPLE_DIV, default 5_000_000, is the number of clock cycles between successive samples; legal range is 2 to 2^24-1.
REQ-002 Parameter N_SAMPLES, default 14, is the number of samples per run; legal range is 1 to 16.
REQ-003 Parameter HEADER, default 8'hA5, is the frame start byte.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port i_Clk, input, width 1: system clock, rising-edge active.
REQ-006 Port i_Rst_n, input, width 1: asynchronous active-low reset.
REQ-007 Port SW, input, width 1: asynchronous run-start switch.
REQ-008 Port i_signal, input, width 14: measured plant/PID signal, synchronous to i_Clk.
REQ-009 Port o_Tx_Byte, output, width 8: byte to the UART transmitter.
REQ-010 Port o_Tx_DV, output, width 1: one-cycle strobe marking o_Tx_Byte valid.
REQ-011 Port i_Tx_Active, input, width 1: the UART transmitter is busy.
REQ-012 Port i_Tx_Done, input, width 1: one-cycle pulse when the transmitter finishes a byte.
REQ-013 Port o_busy, output, width 1: high in any state other than IDLE.
REQ-014 Port o_done, output, width 1: one-cycle pulse when a frame completes.

Function
REQ-015 SW SHALL pass through a 2-flop synchronizer; a start event is a rising edge of the synchronized SW.
REQ-016 States: IDLE, CAPTURE, SEND, WAIT_DONE.
- Transitions: IDLE -> CAPTURE on a start event; CAPTURE -> SEND after sample N_SAMPLES-1 is stored; SEND -> WAIT_DONE after the strobe is issued; WAIT_DONE -> SEND on i_Tx_Done while bytes remain; WAIT_DONE -> IDLE on i_Tx_Done for the last byte.
REQ-017 Start events SHALL be ignored outside IDLE. A held-high SW SHALL produce exactly one run; a new run requires SW low then high again.
REQ-018 CAPTURE timing:
- A 24-bit counter runs 0..SAMPLE_DIV-1 and wraps to 0.
- i_signal is stored into buffer entry k on the cycle the counter is 0, for k = 0..N_SAMPLES-1.
- Sample 0 is stored on the first cycle in CAPTURE, so sample k is stored k*SAMPLE_DIV cycles after CAPTURE entry.
REQ-019 Buffer: 16 x 14-bit registers; contents are undefined until written in a run.
REQ-020 Frame byte order:
- HEADER.
- Then, for each k ascending: {2'b00, sample[13:8]}, then sample[7:0].
- Total 1 + 2*N_SAMPLES bytes.
REQ-021 SEND state:
- While i_Tx_Active is high, hold in SEND with o_Tx_DV low.
- When i_Tx_Active is low, assert o_Tx_DV for exactly one cycle with o_Tx_Byte valid that cycle, then move to WAIT_DONE.
REQ-022 o_Tx_Byte SHALL hold its value from the strobe cycle until the next strobe.
REQ-023 i_Tx_Done SHALL be ignored in every state except WAIT_DONE.
REQ-024 A byte index counts 0..2*N_SAMPLES and SHALL advance only on i_Tx_Done in WAIT_DONE.
REQ-025 o_done SHALL pulse for one cycle, coincident with the WAIT_DONE -> IDLE transition.
REQ-026 A start event arriving during the o_done cycle SHALL be ignored.
REQ-027 No output SHALL depend combinationally on any input.

Reset
REQ-028 While i_Rst_n is low:
- State is IDLE; counter and byte index are 0.
- o_Tx_DV, o_busy and o_done are 0; o_Tx_Byte is 8'h00.
- Synchronizer flops are 0.
REQ-029 Reset asserted mid-run SHALL abandon the run immediately with no further strobes; the buffer need not be cleared.
REQ-030 After reset release, SW already high SHALL count as a start event once it is synchronized (the synchronizer resets to 0).

Verification (SAMPLE_DIV=4, N_SAMPLES=3 unless stated)
REQ-031 i_signal = 14'h2707, 14'h06AF, 14'h3FFF at capture cycles 0, 4, 8 -> bytes A5,27,07,06,AF,3F,FF, each strobed only after the prior i_Tx_Done; o_done pulses once.
REQ-032 SW held high through two full runs' duration -> exactly one frame; SW low-high after o_done -> a second frame.
REQ-033 i_Tx_Active high for 10 cycles at SEND entry -> o_Tx_DV stays low until the cycle after i_Tx_Active falls, then pulses once.
REQ-034 Spurious i_Tx_Done pulses in IDLE, CAPTURE and SEND -> no byte-index advance and no o_Tx_DV.
REQ-035 i_Rst_n low during the third byte's WAIT_DONE -> all outputs 0 within the reset; after release with SW low, no strobes.
REQ-036 Defaults (SAMPLE_DIV=5_000_000, N_SAMPLES=14) -> last sample stored 65_000_000 cycles after CAPTURE entry; frame of 29 bytes.
